// File: rtl/falafel_req_frontend.sv
// falafel_req_frontend: parses header/payload requests into size-classed allocator commands
// and owns the free-list pointer bank.
module falafel_req_frontend #(
    parameter int DATA_W      = 64,
    parameter int NUM_LISTS   = 4,
    parameter int ALIGNMENT   = 8,
    parameter int MIN_PAYLOAD = 32,
    parameter int OPCODE_W    = 4,
    parameter int MSG_ID_W    = 8,
    parameter int REG_ADDR_W  = 16,
    localparam int LIST_W     = NUM_LISTS > 1 ? $clog2(NUM_LISTS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [DATA_W-1:0]           req_data_i,
    output logic                        cmd_valid_o,
    input  logic                        cmd_ready_i,
    output logic                        cmd_is_free_o,
    output logic [MSG_ID_W-1:0]         cmd_id_o,
    output logic [LIST_W-1:0]           cmd_list_o,
    output logic [DATA_W-1:0]           cmd_word_o,
    output logic [NUM_LISTS*DATA_W-1:0] free_list_ptr_o,
    output logic                        err_o
);
    typedef enum logic [1:0] {HDR, PAY, ISSUE} state_t;
    localparam logic [DATA_W-1:0] ALIGN_M = DATA_W'(ALIGNMENT - 1);
    localparam logic [DATA_W-1:0] MIN_SZ  = DATA_W'(MIN_PAYLOAD);
    state_t state, state_nxt;
    logic [OPCODE_W-1:0]   op;
    logic [MSG_ID_W-1:0]   id;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     size_s, size_a;
    logic [LIST_W-1:0]     alloc_cls, free_cls, reg_idx;
    logic fire, ovf, reg_hit, is_wr, is_alloc, is_free, to_issue;
    assign fire     = req_valid_i && req_ready_o;
    assign is_wr    = op == OPCODE_W'(0);
    assign is_alloc = op == OPCODE_W'(1);
    assign is_free  = op == OPCODE_W'(2);
    assign size_s   = req_data_i < MIN_SZ ? MIN_SZ : req_data_i;
    assign size_a   = (size_s + ALIGN_M) & ~ALIGN_M;
    // ~ALIGN_M equals 2^DATA_W - ALIGNMENT: the largest size that rounds up without wrapping
    assign ovf      = req_data_i > ~ALIGN_M;
    assign to_issue = (is_alloc && !ovf) || is_free;
    assign free_cls = NUM_LISTS > 1 ? addr[LIST_W-1:0] : '0;
    always_comb begin
        alloc_cls = LIST_W'(NUM_LISTS - 1);
        for (int i = NUM_LISTS - 1; i >= 0; i--)
            if (size_a <= (MIN_SZ << i)) alloc_cls = LIST_W'(i);
    end
    always_comb begin
        reg_hit = 1'b0;
        reg_idx = '0;
        for (int i = 0; i < NUM_LISTS; i++)
            if (addr == REG_ADDR_W'(16 + 8 * i)) begin
                reg_hit = 1'b1;
                reg_idx = LIST_W'(i);
            end
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= HDR;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            HDR:     state_nxt = fire ? PAY : HDR;
            PAY:     state_nxt = !fire ? PAY : to_issue ? ISSUE : HDR;
            ISSUE:   state_nxt = cmd_ready_i ? HDR : ISSUE;
            default: state_nxt = HDR;
        endcase
    end
    always_comb begin
        req_ready_o = !rst_i && state != ISSUE;
        cmd_valid_o = state == ISSUE;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            op              <= '0;
            id              <= '0;
            addr            <= '0;
            err_o           <= 1'b0;
            cmd_is_free_o   <= 1'b0;
            cmd_id_o        <= '0;
            cmd_list_o      <= '0;
            cmd_word_o      <= '0;
            free_list_ptr_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (fire && state == HDR) begin
                op   <= req_data_i[OPCODE_W-1:0];
                id   <= req_data_i[OPCODE_W +: MSG_ID_W];
                addr <= req_data_i[OPCODE_W+MSG_ID_W +: REG_ADDR_W];
            end
            if (fire && state == PAY) begin
                err_o <= (is_wr && !reg_hit) || (is_alloc && ovf) || !(is_wr || is_alloc || is_free);
                if (is_wr && reg_hit) free_list_ptr_o[reg_idx*DATA_W +: DATA_W] <= req_data_i;
                if (to_issue) begin
                    cmd_is_free_o <= is_free;
                    cmd_id_o      <= id;
                    cmd_list_o    <= is_free ? free_cls : alloc_cls;
                    cmd_word_o    <= is_free ? req_data_i : size_a;
                end
            end
        end
endmodule

// File: tb/tb_falafel_req_frontend.sv
// tb_falafel_req_frontend: directed and randomized checks of the request front end against
// an arithmetic model of its request rules.
module tb_falafel_req_frontend;
    logic         clk = 0, rst = 1;
    logic         req_valid = 0, cmd_ready = 0;
    logic [63:0]  req_data = '0;
    logic         req_ready, cmd_valid, cmd_is_free, err;
    logic [7:0]   cmd_id;
    logic [1:0]   cmd_list;
    logic [63:0]  cmd_word;
    logic [255:0] ptrs;
    logic [63:0]  bank [4];
    int errors = 0, checks = 0;

    falafel_req_frontend dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_data_i(req_data), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_is_free_o(cmd_is_free), .cmd_id_o(cmd_id), .cmd_list_o(cmd_list),
        .cmd_word_o(cmd_word), .free_list_ptr_o(ptrs), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank();
        for (int i = 0; i < 4; i++) chk($sformatf("bank%0d", i), ptrs[i*64 +: 64], bank[i]);
    endtask

    function automatic logic [63:0] hdr(input int op, input int id, input int addr);
        return {36'b0, 16'(addr), 8'(id), 4'(op)};
    endfunction

    // Called at a negedge; returns at the negedge one cycle after the payload handshake.
    task automatic send(input logic [63:0] h, input logic [63:0] p);
        req_valid = 1; req_data = h;
        chk("ready_hdr", req_ready, 1);
        @(posedge clk); @(negedge clk);
        req_data = p;
        chk("ready_pay", req_ready, 1);
        @(posedge clk); @(negedge clk);
        req_valid = 0;
    endtask

    task automatic take(input logic f, input int id, input int list, input logic [63:0] w, input int d);
        for (int k = 0; k <= d; k++) begin
            if (k == d) cmd_ready = 1;
            chk("cmd_valid", cmd_valid, 1);
            chk("ready_issue", req_ready, 0);
            chk("cmd_is_free", cmd_is_free, f);
            chk("cmd_id", cmd_id, id);
            chk("cmd_list", cmd_list, list);
            chk("cmd_word", cmd_word, w);
            @(negedge clk);
        end
        cmd_ready = 0;
        chk("cmd_valid_done", cmd_valid, 0);
        chk("ready_after", req_ready, 1);
        chk("err_cmd", err, 0);
    endtask

    // Model: applies the request rules with plain arithmetic, then checks the DUT response.
    task automatic request(input int op, input int id, input int addr, input logic [63:0] pay, input int d);
        logic [63:0] s, a, lim;
        int cls;
        send(hdr(op, id, addr), pay);
        if (op == 0) begin
            logic hit = addr >= 16 && addr <= 40 && addr % 8 == 0;
            if (hit) bank[(addr - 16) / 8] = pay;
            chk("err_wr", err, !hit);
            chk("cmd_valid_wr", cmd_valid, 0);
            chk_bank();
        end else if (op == 1 && pay <= 64'hFFFF_FFFF_FFFF_FFF8) begin
            s = pay < 32 ? 64'd32 : pay;
            a = ((s + 7) / 8) * 8;
            cls = 0; lim = 32;
            while (a > lim && cls < 3) begin cls++; lim = lim * 2; end
            chk("err_alloc", err, 0);
            take(0, id, cls, a, d);
            return;
        end else if (op == 2) begin
            chk("err_free", err, 0);
            take(1, id, addr % 4, pay, d);
            return;
        end else begin
            chk("err_bad", err, 1);
            chk("cmd_valid_bad", cmd_valid, 0);
        end
        @(negedge clk);
        chk("err_pulse_end", err, 0);
        chk("cmd_valid_idle", cmd_valid, 0);
    endtask

    task automatic chk_all_zero();
        chk("rst_ready", req_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_is_free", cmd_is_free, 0);
        chk("rst_id", cmd_id, 0);
        chk("rst_list", cmd_list, 0);
        chk("rst_word", cmd_word, 0);
        for (int i = 0; i < 4; i++) bank[i] = '0;
        chk_bank();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bank[i] = '0;
        @(negedge clk);
        chk_all_zero();
        rst = 0;
        @(negedge clk);
        chk("ready_post_rst", req_ready, 1);

        request(0, 0, 'h18, 64'h1000, 0);
        request(0, 0, 'h30, 64'hDEAD, 0);
        request(1, 'h5A, 0, 64'd5, 0);
        request(1, 'h11, 0, 64'd33, 1);
        request(1, 'h22, 0, 64'd1000, 0);
        request(1, 'h33, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        request(1, 'h34, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        request(2, 'h44, 2, 64'h2040, 4);
        request(7, 'h55, 0, 64'h1234, 0);
        request(1, 'h66, 0, 64'd64, 0);

        for (int n = 0; n < 60; n++) begin
            int op = $urandom_range(0, 3);
            int id = $urandom_range(0, 255);
            int addr = $urandom_range(0, 1) ? 16 + 8 * $urandom_range(0, 4) : $urandom_range(0, 65535);
            logic [63:0] pay = $urandom_range(0, 3) != 0 ? 64'($urandom_range(0, 1100))
                                                         : {$urandom, $urandom};
            if (op == 3) op = $urandom_range(3, 15);
            if (op == 1 && $urandom_range(0, 7) == 0) pay = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            request(op, id, addr, pay, $urandom_range(0, 2));
        end

        request(0, 0, 'h28, 64'hABCD, 0);
        send(hdr(1, 'h77, 0), 64'd100);
        chk("cmd_valid_pre_rst", cmd_valid, 1);
        rst = 1;
        #1;
        chk_all_zero();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("ready_rel", req_ready, 1);
        chk("cmd_valid_rel", cmd_valid, 0);
        request(1, 'h78, 0, 64'd100, 0);
        request(2, 'h79, 3, 64'h3000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
